twiddle_generator: RTL

// Producer side of the twiddle interface consumed by twiddle_multiplier. For one FFT stage it streams
// the N/2 twiddles W^k = exp(-j*2*pi*k/N), one per butterfly index j, already encoded in the

---
 rtl/twiddle_generator.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/twiddle_generator.sv
// Streams the N/2 twiddles of one FFT stage in the 3-multiply form (real, real+imag, imag-real).
// Values come from a quarter-wave cosine table with symmetry, through a 3-stage stallable pipeline.
module twiddle_generator #(
    parameter int FFT_LEN  = 1024,
    parameter int LOG2N    = 10,
    parameter     ROM_FILE = "twiddle_rom.hex"
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       stage,
    output logic             busy,
    output logic             err,
    output logic             tw_valid,
    input  logic             tw_ready,
    output logic [LOG2N-2:0] tw_index,
    output logic             tw_last,
    output logic [15:0]      twiddle_real,
    output logic [16:0]      twiddle_sum,
    output logic [16:0]      twiddle_diff,
    output logic             done
);

    localparam int              JW        = LOG2N - 1;
    localparam logic [JW-1:0]   QUARTER   = JW'(FFT_LEN / 4);
    localparam logic [JW-1:0]   LAST_J    = JW'(FFT_LEN / 2 - 1);
    localparam logic [3:0]      MAX_STAGE = 4'(LOG2N - 1);
    localparam longint          PI_Q30    = 64'sd3373259426;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    // Elaboration-time cosine (Taylor series in Q30) so the table needs no file load;
    // ROM_FILE names the equivalent hex image for flows that preload memories.
    function automatic logic signed [15:0] cos_q15(input int m);
        longint x, x2, term, acc;
        x    = (PI_Q30 * 2 * longint'(m)) / longint'(FFT_LEN);
        x2   = (x * x) >>> 30;
        term = 64'sd1 <<< 30;
        acc  = term;
        for (int n = 1; n <= 10; n++) begin
            term = -((term * x2) >>> 30) / longint'((2 * n - 1) * (2 * n));
            acc  = acc + term;
        end
        acc = (acc * 32767 + (64'sd1 <<< 29)) >>> 30;
        if (acc < 0) acc = 0;
        return 16'(acc);
    endfunction

    function automatic logic signed [15:0] neg16(input logic signed [15:0] v);
        return -v;
    endfunction

    function automatic logic [16:0] sext17(input logic signed [15:0] v);
        return {v[15], v};
    endfunction

    logic signed [15:0] rom [0:FFT_LEN/4];

    for (genvar g = 0; g <= FFT_LEN / 4; g++) begin : g_rom
        localparam logic signed [15:0] WORD = cos_q15(g);
        assign rom[g] = WORD;
    end

    state_t             state_q, state_d;
    logic [JW-1:0]      j_q, j_d;
    logic [3:0]         s_q, s_d;
    logic               err_q, err_d, done_q, done_d;

    logic               vld_p0_q, vld_p0_d, last_p0_q, last_p0_d, hi_p0_q, hi_p0_d;
    logic [JW-1:0]      j_p0_q, j_p0_d, cos_addr_p0_q, cos_addr_p0_d, sin_addr_p0_q, sin_addr_p0_d;
    logic               vld_p1_q, vld_p1_d, last_p1_q, last_p1_d, hi_p1_q, hi_p1_d;
    logic [JW-1:0]      j_p1_q, j_p1_d;
    logic signed [15:0] cos_p1_q, cos_p1_d, sin_p1_q, sin_p1_d;
    logic               vld_p2_q, vld_p2_d, last_p2_q, last_p2_d;
    logic [JW-1:0]      j_p2_q, j_p2_d;
    logic [15:0]        real_p2_q, real_p2_d;
    logic [16:0]        sum_p2_q, sum_p2_d, diff_p2_q, diff_p2_d;

    logic               adv, hs_last, hi;
    logic [JW-1:0]      k, m;
    logic signed [15:0] tr, ti;

    assign adv     = !vld_p2_q || tw_ready;
    assign hs_last = vld_p2_q && tw_ready && last_p2_q;

    // k = (j << s) mod N/2: truncation to JW bits is the modulo
    assign k  = j_q << s_q;
    assign hi = k[JW-1];
    assign m  = {1'b0, k[JW-2:0]};
    assign tr = hi_p1_q ? neg16(cos_p1_q) : cos_p1_q;
    assign ti = neg16(sin_p1_q);

    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        s_d     = s_q;
        err_d   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (stage > MAX_STAGE) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        j_d     = '0;
                        s_d     = stage;
                    end
                end
            end
            RUN: begin
                if (adv) begin
                    j_d = j_q + 1'b1;
                    if (j_q == LAST_J) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (hs_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        vld_p0_d      = vld_p0_q;
        j_p0_d        = j_p0_q;
        last_p0_d     = last_p0_q;
        hi_p0_d       = hi_p0_q;
        cos_addr_p0_d = cos_addr_p0_q;
        sin_addr_p0_d = sin_addr_p0_q;
        vld_p1_d      = vld_p1_q;
        j_p1_d        = j_p1_q;
        last_p1_d     = last_p1_q;
        hi_p1_d       = hi_p1_q;
        cos_p1_d      = cos_p1_q;
        sin_p1_d      = sin_p1_q;
        vld_p2_d      = vld_p2_q;
        j_p2_d        = j_p2_q;
        last_p2_d     = last_p2_q;
        real_p2_d     = real_p2_q;
        sum_p2_d      = sum_p2_q;
        diff_p2_d     = diff_p2_q;
        if (adv) begin
            // p0: index and quadrant-folded ROM addresses
            vld_p0_d      = (state_q == RUN);
            j_p0_d        = j_q;
            last_p0_d     = (j_q == LAST_J);
            hi_p0_d       = hi;
            cos_addr_p0_d = hi ? QUARTER - m : k;
            sin_addr_p0_d = hi ? m : QUARTER - k;
            // p1: registered ROM read
            vld_p1_d      = vld_p0_q;
            j_p1_d        = j_p0_q;
            last_p1_d     = last_p0_q;
            hi_p1_d       = hi_p0_q;
            cos_p1_d      = rom[cos_addr_p0_q];
            sin_p1_d      = rom[sin_addr_p0_q];
            // p2: sign fix-up and 3-multiply encoding
            vld_p2_d      = vld_p1_q;
            j_p2_d        = j_p1_q;
            last_p2_d     = last_p1_q;
            if (vld_p1_q) begin
                real_p2_d = tr;
                sum_p2_d  = sext17(tr) + sext17(ti);
                diff_p2_d = sext17(ti) - sext17(tr);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            j_q           <= '0;
            s_q           <= '0;
            err_q         <= 1'b0;
            done_q        <= 1'b0;
            vld_p0_q      <= 1'b0;
            j_p0_q        <= '0;
            last_p0_q     <= 1'b0;
            hi_p0_q       <= 1'b0;
            cos_addr_p0_q <= '0;
            sin_addr_p0_q <= '0;
            vld_p1_q      <= 1'b0;
            j_p1_q        <= '0;
            last_p1_q     <= 1'b0;
            hi_p1_q       <= 1'b0;
            cos_p1_q      <= '0;
            sin_p1_q      <= '0;
            vld_p2_q      <= 1'b0;
            j_p2_q        <= '0;
            last_p2_q     <= 1'b0;
            real_p2_q     <= '0;
            sum_p2_q      <= '0;
            diff_p2_q     <= '0;
        end else begin
            state_q       <= state_d;
            j_q           <= j_d;
            s_q           <= s_d;
            err_q         <= err_d;
            done_q        <= done_d;
            vld_p0_q      <= vld_p0_d;
            j_p0_q        <= j_p0_d;
            last_p0_q     <= last_p0_d;
            hi_p0_q       <= hi_p0_d;
            cos_addr_p0_q <= cos_addr_p0_d;
            sin_addr_p0_q <= sin_addr_p0_d;
            vld_p1_q      <= vld_p1_d;
            j_p1_q        <= j_p1_d;
            last_p1_q     <= last_p1_d;
            hi_p1_q       <= hi_p1_d;
            cos_p1_q      <= cos_p1_d;
            sin_p1_q      <= sin_p1_d;
            vld_p2_q      <= vld_p2_d;
            j_p2_q        <= j_p2_d;
            last_p2_q     <= last_p2_d;
            real_p2_q     <= real_p2_d;
            sum_p2_q      <= sum_p2_d;
            diff_p2_q     <= diff_p2_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign err          = err_q;
    assign done         = done_q;
    assign tw_valid     = vld_p2_q;
    assign tw_index     = vld_p2_q ? j_p2_q : '0;
    assign tw_last      = vld_p2_q & last_p2_q;
    assign twiddle_real = real_p2_q;
    assign twiddle_sum  = sum_p2_q;
    assign twiddle_diff = diff_p2_q;

endmodule
